fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_queue.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: redirect/stall from the pipeline, instruction memory port, decode-facing head.
// The slave modport is the fetch queue's view; master is the surrounding pipeline/memory.
interface fetch_queue_if #(
    parameter int unsigned DBITS        = 32,
    parameter int unsigned IMEMADDRBITS = 16,
    parameter int unsigned IMEMWORDBITS = 2
);
    logic                                 redirect_i;
    logic [DBITS-1:0]                     redirect_pc_i;
    logic                                 stall_i;
    logic                                 imem_en_o;
    logic [IMEMADDRBITS-IMEMWORDBITS-1:0] imem_addr_o;
    logic [DBITS-1:0]                     imem_rdata_i;
    logic                                 valid_D_o;
    logic [DBITS-1:0]                     inst_D_o;
    logic [DBITS-1:0]                     pcplus_D_o;
    logic [DBITS-1:0]                     pcpred_D_o;

    modport slave (
        input  redirect_i, redirect_pc_i, stall_i, imem_rdata_i,
        output imem_en_o, imem_addr_o, valid_D_o, inst_D_o, pcplus_D_o, pcpred_D_o
    );

    modport master (
        output redirect_i, redirect_pc_i, stall_i, imem_rdata_i,
        input  imem_en_o, imem_addr_o, valid_D_o, inst_D_o, pcplus_D_o, pcpred_D_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: PC generator, one-deep memory read tracking, 2-entry {inst, pcplus} FIFO.
// Latency: request N, data N+1, valid at decode N+2. Backpressure: stall_i holds the head; issue throttles so data never overflows the FIFO.
module fetch_queue #(
    parameter int unsigned DBITS        = 32,
    parameter logic [31:0] INSTSIZE     = 32'd4,
    parameter logic [31:0] STARTPC      = 32'h100,
    parameter int unsigned IMEMADDRBITS = 16,
    parameter int unsigned IMEMWORDBITS = 2
) (
    input  logic          clk,
    input  logic          RESET_N,
    fetch_queue_if.slave  bus
);
    localparam int EW = int'(2 * DBITS);

    logic [DBITS-1:0] pc_q, pc_d;
    logic [DBITS-1:0] infl_pc_q, infl_pc_d;
    logic             infl_q, infl_d;
    logic [1:0]       count;
    logic [EW-1:0]    head_dat;
    logic [EW-1:0]    push_dat;
    logic             valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic [2:0]       occ;

    assign valid = (count != 2'd0);
    assign pop   = valid & ~bus.stall_i;

    // Occupancy once the current pop and any returning word are accounted for
    assign occ   = {1'b0, count} + {2'b00, infl_q} - {2'b00, pop};
    assign issue = ~bus.redirect_i & (occ < 3'd2);

    assign push     = infl_q & ~bus.redirect_i;
    assign push_dat = {bus.imem_rdata_i, infl_pc_q + DBITS'(INSTSIZE)};

    always_comb begin
        pc_d      = pc_q;
        infl_d    = issue;
        infl_pc_d = infl_pc_q;
        if (bus.redirect_i) begin
            pc_d = bus.redirect_pc_i & ~DBITS'(3);
        end else if (issue) begin
            pc_d      = pc_q + DBITS'(INSTSIZE);
            infl_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q      <= DBITS'(STARTPC);
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    fifo #(
        .WIDTH (EW),
        .DEPTH (2)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (RESET_N),
        .flush_i    (bus.redirect_i),
        .push_vld_i (push),
        .push_dat_i (push_dat),
        .pop_i      (pop & ~bus.redirect_i),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    // Reset gating keeps the request quiet while the rest of the state is held cleared
    assign bus.imem_en_o   = issue & RESET_N;
    assign bus.imem_addr_o = pc_q[IMEMADDRBITS-1:IMEMWORDBITS];
    assign bus.valid_D_o   = valid;
    assign bus.inst_D_o    = head_dat[EW-1:DBITS];
    assign bus.pcplus_D_o  = head_dat[DBITS-1:0];
    assign bus.pcpred_D_o  = head_dat[DBITS-1:0];
endmodule

// Generic synchronous FIFO with flush; storage clears on reset so the head reads zero.
// Latency: push visible at head the cycle after. Backpressure: caller must not push when full without popping.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_vld_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)      rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push_vld_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_vld_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: every issued request queues its expected {inst, pcplus},
// popped and compared when decode consumes the head; directed checks cover reset, stall, redirect and wrap.
module tb_fetch_queue;
    localparam logic [31:0] STARTPC = 32'h100;

    logic clk;
    logic rst_n;

    fetch_queue_if #(.DBITS(32), .IMEMADDRBITS(16), .IMEMWORDBITS(2)) bus ();

    fetch_queue #(
        .DBITS        (32),
        .INSTSIZE     (32'd4),
        .STARTPC      (STARTPC),
        .IMEMADDRBITS (16),
        .IMEMWORDBITS (2)
    ) dut (
        .clk     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [13:0] a);
        return 32'hC0DE_0000 | {18'b0, a};
    endfunction

    // Instruction memory: word address sampled mid-cycle, data presented the following cycle
    logic        req_en_s = 1'b0;
    logic [13:0] req_addr_s = '0;
    always @(negedge clk) begin
        req_en_s   = bus.imem_en_o;
        req_addr_s = bus.imem_addr_o;
    end
    always @(posedge clk) begin
        #1;
        bus.imem_rdata_i = req_en_s ? word_of(req_addr_s) : 32'hBAD0_BAD0;
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pcplus;
        int          icyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_pc = STARTPC;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        int   landed;
        int   infl;
        logic exp_vld;
        logic popx;
        logic exp_en;
        if (!rst_n) begin
            chk("rst_valid",  32'(bus.valid_D_o), 32'h0);
            chk("rst_inst",   bus.inst_D_o,       32'h0);
            chk("rst_pcplus", bus.pcplus_D_o,     32'h0);
            chk("rst_pcpred", bus.pcpred_D_o,     32'h0);
            chk("rst_en",     32'(bus.imem_en_o), 32'h0);
            sb.delete();
            exp_pc = STARTPC;
        end else begin
            landed = 0;
            infl   = 0;
            foreach (sb[i]) begin
                if (sb[i].icyc + 2 <= cyc) landed++;
                else if (sb[i].icyc == cyc - 1) infl++;
            end
            exp_vld = (landed != 0);
            chk("valid", 32'(bus.valid_D_o), 32'(exp_vld));
            popx   = exp_vld && !bus.stall_i;
            exp_en = !bus.redirect_i && ((landed - int'(popx) + infl) < 2);
            chk("imem_en", 32'(bus.imem_en_o), 32'(exp_en));
            if (exp_en) chk("imem_addr", 32'(bus.imem_addr_o), 32'(exp_pc[15:2]));
            if (popx && sb.size() > 0) begin
                chk("inst",   bus.inst_D_o,   sb[0].inst);
                chk("pcplus", bus.pcplus_D_o, sb[0].pcplus);
                chk("pcpred", bus.pcpred_D_o, sb[0].pcplus);
                void'(sb.pop_front());
            end
            if (bus.redirect_i) begin
                sb.delete();
                exp_pc = bus.redirect_pc_i & ~32'h3;
            end else if (bus.imem_en_o) begin
                sb.push_back('{inst: word_of(exp_pc[15:2]), pcplus: exp_pc + 32'd4, icyc: cyc});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] h_inst;
    logic [31:0] h_pc;

    initial begin
        rst_n             = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.imem_rdata_i  = '0;
        repeat (3) @(negedge clk);

        // Reset release: consecutive word addresses, head appears two cycles after first request
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("start_addr0", 32'(bus.imem_addr_o), 32'h040);
        chk("start_vld0",  32'(bus.valid_D_o),   32'h0);
        @(negedge clk);
        chk("start_addr1", 32'(bus.imem_addr_o), 32'h041);
        @(negedge clk);
        chk("start_addr2", 32'(bus.imem_addr_o), 32'h042);
        chk("start_vld2",  32'(bus.valid_D_o),   32'h1);
        chk("start_pc0",   bus.pcplus_D_o,       32'h104);
        @(negedge clk);
        chk("start_pc1",   bus.pcplus_D_o,       32'h108);
        @(negedge clk);
        chk("start_pc2",   bus.pcplus_D_o,       32'h10C);

        // Stall from steady state: head frozen, requests stop once full
        step();
        bus.stall_i = 1'b1;
        @(negedge clk);
        h_inst = bus.inst_D_o;
        h_pc   = bus.pcplus_D_o;
        repeat (4) begin
            @(negedge clk);
            chk("stall_inst",   bus.inst_D_o,   h_inst);
            chk("stall_pcplus", bus.pcplus_D_o, h_pc);
        end
        chk("stall_en", 32'(bus.imem_en_o), 32'h0);
        step();
        bus.stall_i = 1'b0;
        repeat (6) step();

        // Redirect with a full queue
        bus.stall_i = 1'b1;
        repeat (3) step();
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        step();
        bus.redirect_i = 1'b0;
        @(negedge clk);
        chk("redir_vld",  32'(bus.valid_D_o),   32'h0);
        chk("redir_addr", 32'(bus.imem_addr_o), 32'h080);
        @(negedge clk);
        @(negedge clk);
        chk("redir_hvld", 32'(bus.valid_D_o),   32'h1);
        chk("redir_hpc",  bus.pcplus_D_o,       32'h204);

        // Redirect together with stall, unaligned target
        step();
        bus.redirect_i    = 1'b1;
        bus.stall_i       = 1'b1;
        bus.redirect_pc_i = 32'h203;
        step();
        bus.redirect_i = 1'b0;
        bus.stall_i    = 1'b0;
        @(negedge clk);
        chk("rs_vld",  32'(bus.valid_D_o),   32'h0);
        chk("rs_addr", 32'(bus.imem_addr_o), 32'h080);
        repeat (4) step();

        // Asynchronous reset pulse between edges with a full queue
        bus.stall_i = 1'b1;
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",    32'(bus.valid_D_o), 32'h0);
        chk("arst_inst",   bus.inst_D_o,       32'h0);
        chk("arst_pcplus", bus.pcplus_D_o,     32'h0);
        chk("arst_pcpred", bus.pcpred_D_o,     32'h0);
        chk("arst_en",     32'(bus.imem_en_o), 32'h0);
        sb.delete();
        exp_pc = STARTPC;
        #1;
        rst_n       = 1'b1;
        bus.stall_i = 1'b0;
        @(negedge clk);
        chk("arst_addr", 32'(bus.imem_addr_o), 32'h040);
        repeat (4) step();

        // PC wrap at the top of the address space
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        step();
        bus.redirect_i = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", 32'(bus.imem_addr_o), 32'h3FFF);
        @(negedge clk);
        chk("wrap_addr1", 32'(bus.imem_addr_o), 32'h0000);
        @(negedge clk);
        chk("wrap_vld",    32'(bus.valid_D_o), 32'h1);
        chk("wrap_pcplus", bus.pcplus_D_o,     32'h0);
        repeat (3) step();

        // Random stall/redirect traffic, scoreboard does the checking
        for (int i = 0; i < 300; i++) begin
            bus.stall_i       = ($urandom_range(0, 3) == 0);
            bus.redirect_i    = ($urandom_range(0, 24) == 0);
            bus.redirect_pc_i = $urandom;
            step();
        end
        bus.stall_i    = 1'b0;
        bus.redirect_i = 1'b0;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
